// File: rtl/uart_tx_arbiter.sv
// Two-channel, frame-locked arbiter in front of a single UART byte transmitter.
// Define UART_ARB_RR_EN for round-robin unlocked arbitration (default: fixed ch0 > ch1).
module uart_tx_arbiter #(
    parameter int BSY_TO  = 255,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_bsy,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        fault,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP} state_t;

    localparam logic [7:0] BSY_TO_C = 8'(BSY_TO);
    localparam logic [7:0] GAP_C    = 8'(GAP_CYC);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        lock_q, lock_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        ready0_q, ready0_d;
    logic        ready1_q, ready1_d;

    logic pick_valid, pick_ch, own_valid;
    logic load, load_ch, rel;

    assign pick_valid = req0_valid | req1_valid;
    assign own_valid  = owner_q ? req1_valid : req0_valid;

`ifdef UART_ARB_RR_EN
    logic pri_q, pri_d;
    // pri_q names the channel that wins a tie; it flips away from whoever just finished.
    assign pick_ch = (req0_valid && req1_valid) ? pri_q : req1_valid;
    assign pri_d   = rel ? ~owner_q : pri_q;
`else
    assign pick_ch = !req0_valid;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        fault_d     = fault_q;
        frame_cnt_d = frame_cnt_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        ready0_d    = 1'b0;
        ready1_d    = 1'b0;
        load        = 1'b0;
        load_ch     = owner_q;
        rel         = 1'b0;
        case (state_q)
            IDLE: begin
                if (lock_q) begin
                    load = own_valid;
                end else if (pick_valid) begin
                    load    = 1'b1;
                    load_ch = pick_ch;
                    owner_d = pick_ch;
                    grant_d = pick_ch ? 2'b10 : 2'b01;
                end
            end
            LOAD: begin
                state_d    = START;
                tx_start_d = 1'b1;
            end
            START: begin
                state_d = WAIT_HI;
                cnt_d   = BSY_TO_C;
            end
            WAIT_HI: begin
                if (tx_bsy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q <= 8'd1) begin
                    fault_d = 1'b1;
                    rel     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_LO: begin
                if (!tx_bsy) begin
                    state_d = GAP;
                    cnt_d   = GAP_C;
                end
            end
            GAP: begin
                // A zero gap still spends one cycle here.
                if (cnt_q <= 8'd1) begin
                    state_d = IDLE;
                    if (last_q) begin
                        rel         = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        lock_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Capture on entry to LOAD so tx_data is already stable the cycle before tx_start.
        if (load) begin
            state_d   = LOAD;
            tx_data_d = load_ch ? req1_data : req0_data;
            last_d    = load_ch ? req1_last : req0_last;
            ready0_d  = !load_ch;
            ready1_d  = load_ch;
        end
        if (rel) begin
            state_d = IDLE;
            lock_d  = 1'b0;
            grant_d = 2'b00;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lock_q      <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= 8'd0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
`ifdef UART_ARB_RR_EN
            pri_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            frame_cnt_q <= frame_cnt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            ready0_q    <= ready0_d;
            ready1_q    <= ready1_d;
`ifdef UART_ARB_RR_EN
            pri_q       <= pri_d;
`endif
        end
    end

    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, directed scenarios and randomized
// frame streams checked against a frame-order reference model.
module tb_uart_tx_arbiter;

    localparam int BSY_TO  = 255;
    localparam int GAP_CYC = 2;
`ifdef UART_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_last, req0_ready;
    logic [7:0]  req0_data;
    logic        req1_valid, req1_last, req1_ready;
    logic [7:0]  req1_data;
    logic        tx_start, tx_bsy;
    logic [7:0]  tx_data;
    logic [1:0]  grant;
    logic        busy, fault;
    logic [15:0] frame_cnt;

    uart_tx_arbiter #(.BSY_TO(BSY_TO), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_bsy(tx_bsy),
        .grant(grant), .busy(busy), .fault(fault), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmitter model: bsy rises one cycle after tx_start, stays high bsy_len cycles.
    int bsy_len   = 400;
    bit bsy_never = 1'b0;
    int hi_wait   = 0;
    int hi_left   = 0;
    int fall_cyc  = 0;
    initial begin
        tx_bsy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                tx_bsy = 1'b0; hi_wait = 0; hi_left = 0;
            end else if (hi_left > 0) begin
                hi_left--;
                if (hi_left == 0) begin tx_bsy = 1'b0; fall_cyc = cyc; end
            end else if (hi_wait > 0) begin
                hi_wait = 0; tx_bsy = 1'b1; hi_left = bsy_len;
            end else if (tx_start && !bsy_never) begin
                hi_wait = 1;
            end
        end
    end

    // Monitor: one event per tx_start.
    typedef struct {
        logic [7:0]  d;
        logic [1:0]  g;
        int          c;
        int          gap;
        logic [15:0] fc;
    } ev_t;
    ev_t evq[$];
    int  rcnt0 = 0, rcnt1 = 0, dup_err = 0;
    bit  prev_start = 1'b0;
    initial forever begin
        ev_t e;
        @(negedge clk);
        if (tx_start === 1'b1) begin
            e.d = tx_data; e.g = grant; e.c = cyc; e.gap = cyc - fall_cyc; e.fc = frame_cnt;
            evq.push_back(e);
            if (prev_start) dup_err++;
        end
        if (req0_ready === 1'b1 && req1_ready === 1'b1) dup_err++;
        prev_start = (tx_start === 1'b1);
        if (req0_ready === 1'b1) rcnt0++;
        if (req1_ready === 1'b1) rcnt1++;
    end

    function automatic ev_t ev_at(input int i);
        ev_t e;
        e.d = 'x; e.g = 'x; e.c = -1; e.gap = -1; e.fc = 'x;
        if (i < evq.size()) e = evq[i];
        return e;
    endfunction

    // Stimulus store: per channel, bytes with last flags, sent back to back.
    logic [7:0] sd[2][64];
    bit         sl[2][64];
    int         sn[2];
    int         vld_cyc[2];
    int         rdy_cyc[2];

    task automatic clr();
        sn[0] = 0; sn[1] = 0;
    endtask

    task automatic add(input int ch, input logic [7:0] d, input bit l);
        sd[ch][sn[ch]] = d; sl[ch][sn[ch]] = l; sn[ch]++;
    endtask

    task automatic set_req(input int ch, input bit v, input logic [7:0] d, input bit l);
        if (ch == 0) begin req0_valid = v; req0_data = d; req0_last = l; end
        else         begin req1_valid = v; req1_data = d; req1_last = l; end
    endtask

    task automatic drv(input int ch);
        for (int i = 0; i < sn[ch]; i++) begin
            bit got = 1'b0;
            set_req(ch, 1'b1, sd[ch][i], sl[ch][i]);
            if (i == 0) vld_cyc[ch] = cyc;
            for (int t = 0; t < 3000 && !got; t++) begin
                @(negedge clk);
                got = (ch == 0) ? req0_ready : req1_ready;
            end
            if (!got) begin
                chk("ready_timeout", 32'(got), 32'd1);
                break;
            end
            rdy_cyc[ch] = cyc;
        end
        set_req(ch, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic wait_quiet();
        int q = 0;
        for (int t = 0; t < 5000 && q < 3; t++) begin
            @(negedge clk);
            if (!busy && !tx_bsy && !req0_valid && !req1_valid) q++;
            else q = 0;
        end
        if (q < 3) chk("quiet_timeout", q, 3);
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, grant, busy, fault, tx_start, req0_ready, req1_ready, tx_data, frame_cnt};
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1 chk(tag, outs(), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base, r0, r1, rr0, nfr;
        logic [7:0] expq[$];
        rst = 1'b1;
        req0_valid = 1'b0; req0_data = 8'd0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'd0; req1_last = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        do_reset("reset_outs");
        chk("idle_outs", outs(), 32'd0);

        // Single-byte frame on ch0
        bsy_len = 400; base = evq.size(); r0 = rcnt0;
        clr(); add(0, 8'h5A, 1'b1);
        drv(0); wait_quiet();
        chk("t1_nstart", evq.size() - base, 1);
        chk("t1_data", ev_at(base).d, 8'h5A);
        chk("t1_latency", ev_at(base).c - vld_cyc[0], 2);
        chk("t1_ready", rcnt0 - r0, 1);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_grant", grant, 2'b00);

        // Frame lock: ch1 three-byte frame, ch0 shows up during byte 2
        do_reset("t2_reset");
        bsy_len = 6; base = evq.size(); r1 = rcnt1;
        clr();
        add(1, 8'h01, 1'b0); add(1, 8'h02, 1'b0); add(1, 8'h03, 1'b1);
        add(0, 8'hAA, 1'b1);
        fork
            drv(1);
            begin
                for (int t = 0; t < 2000 && rcnt1 - r1 < 2; t++) @(negedge clk);
                drv(0);
            end
        join
        wait_quiet();
        expq = '{8'h01, 8'h02, 8'h03, 8'hAA};
        for (int k = 0; k < 4; k++) begin
            chk("t2_byte", ev_at(base + k).d, expq[k]);
            chk("t2_grant", ev_at(base + k).g, (k < 3) ? 2'b10 : 2'b01);
            if (k > 0) chk("t2_gap", ev_at(base + k).gap, GAP_CYC + 3);
        end
        chk("t2_fc_mid", ev_at(base + 3).fc, 1);
        chk("t2_frame_cnt", frame_cnt, 2);

        // Simultaneous single-byte requests
        do_reset("t3_reset");
        bsy_len = 3; base = evq.size();
        clr(); add(0, 8'h11, 1'b1); add(1, 8'h22, 1'b1);
        fork drv(0); drv(1); join
        wait_quiet();
        chk("t3_first", ev_at(base).d, 8'h11);
        chk("t3_second", ev_at(base + 1).d, 8'h22);
        chk("t3_latency", ev_at(base).c - vld_cyc[0], 2);
        chk("t3_frame_cnt", frame_cnt, 2);

        // Busy timeout, then a normal ch1 byte
        do_reset("t4_reset");
        bsy_never = 1'b1; base = evq.size(); r0 = rcnt0;
        clr(); add(0, 8'hC3, 1'b1);
        drv(0);
        rr0 = rdy_cyc[0];
        while (cyc < rr0 + 256) @(negedge clk);
        chk("t4_start_cyc", ev_at(base).c, rr0 + 1);
        chk("t4_waiting", {busy, fault}, 2'b10);
        @(negedge clk);
        chk("t4_fault", {fault, busy, grant}, 4'b1000);
        chk("t4_ready", rcnt0 - r0, 1);
        bsy_never = 1'b0; bsy_len = 5;
        clr(); add(1, 8'h77, 1'b1);
        drv(1); wait_quiet();
        chk("t4_after", ev_at(base + 1).d, 8'h77);
        chk("t4_frame_cnt", frame_cnt, 1);
        chk("t4_sticky", fault, 1'b1);

        // Reset while the transmitter is busy
        do_reset("t5_reset");
        bsy_len = 400;
        clr(); add(0, 8'h99, 1'b1);
        drv(0);
        for (int t = 0; t < 50 && !tx_bsy; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1 chk("t5_midbyte_rst", outs(), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bsy_len = 4; base = evq.size();
        clr(); add(0, 8'h3C, 1'b1);
        drv(0); wait_quiet();
        chk("t5_byte", ev_at(base).d, 8'h3C);
        chk("t5_fc_pre", ev_at(base).fc, 0);
        chk("t5_frame_cnt", frame_cnt, 1);

        // Randomized back-to-back frame streams on both channels
        for (int r = 0; r < 4; r++) begin
            int pos[2];
            int turn, ch;
            do_reset("rnd_reset");
            bsy_len = $urandom_range(1, 12);
            base = evq.size(); r0 = rcnt0; r1 = rcnt1; nfr = 0;
            clr();
            for (int c = 0; c < 2; c++) begin
                int nf = $urandom_range(1, 3);
                for (int f = 0; f < nf; f++) begin
                    int nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++) add(c, 8'($urandom), b == nb - 1);
                    nfr++;
                end
            end
            // Reference: whole frames; ch0 wins ties, or alternate when round-robin.
            expq.delete();
            pos[0] = 0; pos[1] = 0; turn = 0;
            while (pos[0] < sn[0] || pos[1] < sn[1]) begin
                if (pos[1] >= sn[1])      ch = 0;
                else if (pos[0] >= sn[0]) ch = 1;
                else                      ch = RR ? turn : 0;
                do begin
                    expq.push_back(sd[ch][pos[ch]]);
                    pos[ch]++;
                end while (!sl[ch][pos[ch] - 1]);
                turn = 1 - ch;
            end
            fork drv(0); drv(1); join
            wait_quiet();
            chk("rnd_count", evq.size() - base, expq.size());
            for (int k = 0; k < expq.size(); k++) chk("rnd_byte", ev_at(base + k).d, expq[k]);
            chk("rnd_frame_cnt", frame_cnt, nfr);
            chk("rnd_ready0", rcnt0 - r0, sn[0]);
            chk("rnd_ready1", rcnt1 - r1, sn[1]);
        end

        chk("pulse_shape", dup_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
